// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// slave  = the adder side, master = the producer/consumer side.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Slice-pipelined add/subtract unit.
// Stage k adds bit slice k of A and the effective B with the carry registered
// by stage k-1. Operand bits not yet consumed travel up the pipe with the
// operation, and finished low result slices are carried forward, so every
// operation leaves the last stage fully aligned. One global advance enable
// stalls the whole pipe when the consumer holds off; bubbles are kept.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  // Width of the slice handled by each stage.
  localparam int SW = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Combinational outputs of the final stage, captured by the output registers.
  logic [WIDTH-1:0] w_fin_sum;
  logic             w_fin_carry;
  logic             w_fin_valid;
  logic             w_fin_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  // Everything moves together, or nothing moves: the pipe only stalls when a
  // finished result is waiting and the consumer is not taking it.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Subtraction is a + ~b + 1; the carry-in port is ignored in that mode.
  assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
  assign w_cin_eff = bus.sub ? 1'b1 : bus.cin;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand bits still to be consumed from this stage upwards.
      localparam int AW = WIDTH - gi * SW;
      // Result bits complete once this stage has added its slice.
      localparam int RW = (gi + 1) * SW;

      logic [AW-1:0] w_a_src;
      logic [AW-1:0] w_b_src;
      logic          w_c_src;
      logic          w_v_src;
      logic [SW:0]   w_slice;
      logic [RW-1:0] w_sum;

      // Slice add with carry; the extra top bit is the carry into the next slice.
      assign w_slice = {1'b0, w_a_src[SW-1:0]} + {1'b0, w_b_src[SW-1:0]}
                     + {{SW{1'b0}}, w_c_src};

      if (gi == 0) begin : g_first
        assign w_a_src = bus.a;
        assign w_b_src = w_b_eff;
        assign w_c_src = w_cin_eff;
        assign w_v_src = bus.in_valid;
        assign w_sum   = w_slice[SW-1:0];
      end else begin : g_next
        assign w_a_src = g_stage[gi-1].g_reg.r_a;
        assign w_b_src = g_stage[gi-1].g_reg.r_b;
        assign w_c_src = g_stage[gi-1].g_reg.r_c;
        assign w_v_src = g_stage[gi-1].g_reg.r_v;
        assign w_sum   = {w_slice[SW-1:0], g_stage[gi-1].g_reg.r_sum};
      end

      if (gi < STAGES - 1) begin : g_reg
        logic [AW-SW-1:0] r_a;
        logic [AW-SW-1:0] r_b;
        logic             r_c;
        logic             r_v;
        logic [RW-1:0]    r_sum;

        // Stage register: keep the higher operand bits, the slice carry and the
        // result bits produced so far; hold everything when the pipe stalls.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_sum <= '0;
          end else if (w_adv) begin
            r_a   <= w_a_src[AW-1:SW];
            r_b   <= w_b_src[AW-1:SW];
            r_c   <= w_slice[SW];
            r_v   <= w_v_src;
            r_sum <= w_sum;
          end
        end
      end else begin : g_last
        // The top slice still holds the operand sign bits, so signed overflow
        // is decided here from the same bits that produce the result MSB.
        assign w_fin_sum   = w_sum;
        assign w_fin_carry = w_slice[SW];
        assign w_fin_valid = w_v_src;
        assign w_fin_ovf   = (w_a_src[AW-1] == w_b_src[AW-1])
                          && (w_sum[RW-1] != w_a_src[AW-1]);
      end
    end
  endgenerate

  // Output register: the last pipeline stage. All flags are registered so they
  // read 0 in reset and stay frozen together with the result during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_fin_valid;
      r_result    <= w_fin_sum;
      r_carry     <= w_fin_carry;
      r_ovf       <= w_fin_ovf;
      r_zero      <= (w_fin_sum == '0);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed table, stall/reset sequences, random
// traffic scored against an arithmetic reference, and an 8-bit/1-stage build.
module tb_pipelined_adder;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  logic clk;
  logic rst_n;

  pipelined_adder_if #(.WIDTH(32)) if32 ();
  pipelined_adder_if #(.WIDTH(8))  if8 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_out  = 0;
  res_t sb_q[$];
  bit   stall_prev = 1'b0;
  res_t hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input bit cin, input bit sub);
    res_t r;
    longint unsigned mask;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned usum;
    longint sa;
    longint sb;
    longint ssum;
    longint smax;
    longint smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sa > smax) sa = sa - (longint'(1) << w);
    if (sb > smax) sb = sb - (longint'(1) << w);
    if (sub) begin
      usum    = (ua - ub) & mask;
      r.carry = (ua >= ub);
      ssum    = sa - sb;
    end else begin
      usum    = ua + ub + longint'(cin);
      r.carry = (usum > mask);
      usum    = usum & mask;
      ssum    = sa + sb + longint'(cin);
    end
    r.ovf    = (ssum > smax) || (ssum < smin);
    r.zero   = (usum == 0);
    r.result = usum[31:0];
    return r;
  endfunction

  // One cycle of scoreboarded traffic on the 32-bit instance.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input bit cin, input bit sub, input bit ordy,
                      output bit acc, output bit rdy);
    res_t e;
    @(negedge clk);
    if32.in_valid  = iv;
    if32.a         = a;
    if32.b         = b;
    if32.cin       = cin;
    if32.sub       = sub;
    if32.out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("hold_valid",  if32.out_valid, 1);
      chk("hold_result", if32.result,    hold.result);
      chk("hold_carry",  if32.carry_out, hold.carry);
      chk("hold_ovf",    if32.overflow,  hold.ovf);
      chk("hold_zero",   if32.zero,      hold.zero);
    end
    if (if32.out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_out: got result 0x%0h with nothing outstanding", if32.result);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", if32.result,    e.result);
        chk("sb_carry",  if32.carry_out, e.carry);
        chk("sb_ovf",    if32.overflow,  e.ovf);
        chk("sb_zero",   if32.zero,      e.zero);
        n_out++;
      end
    end
    stall_prev  = if32.out_valid && !ordy;
    hold.result = if32.result;
    hold.carry  = if32.carry_out;
    hold.ovf    = if32.overflow;
    hold.zero   = if32.zero;
    rdy = if32.in_ready;
    acc = iv && rdy;
    if (acc) sb_q.push_back(model(32, a, b, cin, sub));
  endtask

  // Single operation into an empty pipe: exact latency and all result fields.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
    lat = 0;
    r = '0; c = 1'b0; o = 1'b0; z = 1'b0;
    @(negedge clk);
    if32.in_valid  = 1'b1;
    if32.a         = v.a;
    if32.b         = v.b;
    if32.cin       = v.cin;
    if32.sub       = v.sub;
    if32.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if32.in_valid = 1'b0;
      #1;
      if (if32.out_valid && lat == 0) begin
        lat = k;
        r = if32.result; c = if32.carry_out; o = if32.overflow; z = if32.zero;
      end
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_result"},  r,   v.r);
    chk({tag, "_carry"},   c,   v.c);
    chk({tag, "_ovf"},     o,   v.v);
    chk({tag, "_zero"},    z,   v.z);
    $display("vec %s: a=%08h b=%08h cin=%0d sub=%0d -> %08h c=%0d v=%0d z=%0d lat=%0d",
             tag, v.a, v.b, v.cin, v.sub, r, c, o, z, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    bit   acc;
    bit   rdy;
    int   idx;
    int   out0;
    logic [31:0] oa[8];
    logic [31:0] ob[8];
    res_t e8;
    bit   have8;
    logic [7:0] a8;
    logic [7:0] b8;
    bit   c8;
    bit   s8;

    tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0, 32'h1235_5678, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0;
    if32.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
    if8.out_ready = 1'b1;

    // Reset state of both instances.
    #1;
    chk("rst_out_valid", if32.out_valid, 0);
    chk("rst_result",    if32.result,    0);
    chk("rst_carry",     if32.carry_out, 0);
    chk("rst_ovf",       if32.overflow,  0);
    chk("rst_zero",      if32.zero,      0);
    chk("rst_in_ready",  if32.in_ready,  1);
    chk("rst8_out_valid", if8.out_valid, 0);
    chk("rst8_zero",      if8.zero,      0);
    chk("rst8_in_ready",  if8.in_ready,  1);
    $display("reset: out_valid=%0d in_ready=%0d", if32.out_valid, if32.in_ready);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", if32.in_ready, 1);

    // Directed vectors.
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Eight back-to-back operations with the consumer stalling in cycles 6..8.
    for (int i = 0; i < 8; i++) begin
      oa[i] = $urandom();
      ob[i] = $urandom();
    end
    idx  = 0;
    out0 = n_out;
    for (int c = 0; c < 24; c++) begin
      step(idx < 8, oa[idx % 8], ob[idx % 8], idx[0], idx[1], !(c >= 6 && c <= 8), acc, rdy);
      chk($sformatf("b2b_in_ready_c%0d", c), rdy, !(c >= 6 && c <= 8));
      $display("b2b cycle %0d: in_ready=%0d accepted=%0d op=%0d out_valid=%0d result=%08h",
               c, rdy, acc, idx, if32.out_valid, if32.result);
      if (acc) idx++;
    end
    chk("b2b_count", n_out - out0, 8);
    chk("b2b_drained", sb_q.size(), 0);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: ra = 32'h7FFF_FFFF;
        1: rb = 32'h8000_0000;
        2: rb = ra;
        3: rb = ~ra;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, acc, rdy);
      if (acc) $display("rnd cycle %0d: accepted a=%08h b=%08h", c, ra, rb);
    end
    for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, rdy);
    chk("rnd_drained", sb_q.size(), 0);

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 * (i + 1), 32'h3, 1'b0, 1'b0, 1'b1, acc, rdy);
    @(negedge clk);
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    #1;
    chk("pre_rst_out_valid", if32.out_valid, 1);
    chk("pre_rst_result", if32.result, 32'h103);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", if32.out_valid, 0);
    chk("mid_rst_result",    if32.result,    0);
    chk("mid_rst_carry",     if32.carry_out, 0);
    chk("mid_rst_ovf",       if32.overflow,  0);
    chk("mid_rst_zero",      if32.zero,      0);
    chk("mid_rst_in_ready",  if32.in_ready,  1);
    $display("mid-op reset: out_valid=%0d result=%08h", if32.out_valid, if32.result);
    sb_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_idle%0d", k), if32.out_valid, 0);
    end
    run_vec(tbl[0], "after_rst");

    // 8-bit, single-stage build: 0x80 - 0x01.
    @(negedge clk);
    if8.in_valid = 1'b1; if8.a = 8'h80; if8.b = 8'h01; if8.cin = 1'b0; if8.sub = 1'b1;
    if8.out_ready = 1'b1;
    #1;
    chk("w8_before_edge_valid", if8.out_valid, 0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    #1;
    chk("w8_latency1_valid", if8.out_valid, 1);
    chk("w8_result", if8.result,    8'h7F);
    chk("w8_ovf",    if8.overflow,  1);
    chk("w8_carry",  if8.carry_out, 1);
    chk("w8_zero",   if8.zero,      0);
    $display("w8: 80-01 -> %02h c=%0d v=%0d", if8.result, if8.carry_out, if8.overflow);
    @(negedge clk);

    // 8-bit streaming: one op per cycle, each result due one cycle later.
    have8 = 1'b0;
    e8 = '{32'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      a8 = 8'($urandom());
      b8 = 8'($urandom());
      c8 = 1'($urandom_range(0, 1));
      s8 = 1'($urandom_range(0, 1));
      if8.in_valid = (i < 24);
      if8.a = a8; if8.b = b8; if8.cin = c8; if8.sub = s8;
      #1;
      if (have8) begin
        chk("w8s_valid",  if8.out_valid, 1);
        chk("w8s_result", if8.result,    e8.result[7:0]);
        chk("w8s_carry",  if8.carry_out, e8.carry);
        chk("w8s_ovf",    if8.overflow,  e8.ovf);
        chk("w8s_zero",   if8.zero,      e8.zero);
        $display("w8 stream %0d: result=%02h c=%0d v=%0d z=%0d", i, if8.result,
                 if8.carry_out, if8.overflow, if8.zero);
      end
      have8 = (i < 24);
      if (have8) e8 = model(8, 64'(a8), 64'(b8), c8, s8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
